// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared types and decode helpers for the RV32I decode stage.
//               Opcode constants, immediate-format enum, the decoded bundle
//               struct and the combinational decode_instr() function.
//               Optional feature macro: DECODE_ILLEGAL_TRAP_EN (flags opcodes
//               outside the RV32I base set as illegal).
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int c_xlen = 32;

    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_op       = 7'b0110011;
    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    // Raw fetch entry held in the skid buffer.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    // Fully decoded bundle presented to execute.
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        rd_we;
        logic        illegal;
    } decoded_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        imm_fmt_e fmt;
        case (opc)
            c_opc_load, c_opc_op_imm, c_opc_jalr, c_opc_system: fmt = IMM_I;
            c_opc_store:                                        fmt = IMM_S;
            c_opc_branch:                                       fmt = IMM_B;
            c_opc_lui, c_opc_auipc:                             fmt = IMM_U;
            c_opc_jal:                                          fmt = IMM_J;
            default:                                            fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc);
        return (opc == c_opc_lui)  || (opc == c_opc_auipc)  || (opc == c_opc_jal) ||
               (opc == c_opc_jalr) || (opc == c_opc_load)   || (opc == c_opc_op_imm) ||
               (opc == c_opc_op);
    endfunction

    function automatic logic known_opcode(input logic [6:0] opc);
        return writes_rd(opc) || (opc == c_opc_store) || (opc == c_opc_branch) ||
               (opc == c_opc_misc_mem) || (opc == c_opc_system);
    endfunction

    function automatic decoded_t decode_instr(input logic [31:0] pc, input logic [31:0] instr);
        decoded_t d;
        d        = '0;
        d.pc     = pc;
        d.opcode = instr[6:0];
        d.rd     = instr[11:7];
        d.funct3 = instr[14:12];
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.funct7 = instr[31:25];
        case (imm_fmt(instr[6:0]))
            IMM_I:   d.imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   d.imm = {instr[31:12], 12'b0};
            IMM_J:   d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        // Unknown opcodes are never writers, so rd_we is already 0 for them.
        d.rd_we = writes_rd(instr[6:0]) && (instr[11:7] != 5'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        d.illegal = !known_opcode(instr[6:0]);
        if (d.illegal) begin
            d.rd_we = 1'b0;
        end
`else
        d.illegal = 1'b0;
`endif
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_if
// Description : Fetch->decode->execute handshake bundle.
//               slave  : decode side (consumes fetch, produces decoded bundle)
//               master : environment side (fetch producer / execute consumer)
//               Ports : in_valid/in_pc/in_instr/in_ready (fetch handshake),
//                       flush, out_valid/out_ready and decoded out_* fields.
// Revision    : 1.0 - initial release
// ============================================================================
import decode_pkg::*;

interface decode_if;
    logic                in_valid;
    logic [c_xlen-1:0]   in_pc;
    logic [31:0]         in_instr;
    logic                in_ready;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [c_xlen-1:0]   out_pc;
    logic [6:0]          out_opcode;
    logic [4:0]          out_rd;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [2:0]          out_funct3;
    logic [6:0]          out_funct7;
    logic [31:0]         out_imm;
    logic                out_rd_we;
    logic                out_illegal;

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_rd_we, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7, out_imm, out_rd_we, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : decode_skid_buffer
// Description : 2-entry FIFO of {pc, instr} in front of the decode output
//               register. Flush and reset empty it; flush beats push.
//               Ports : clk, rst_n, i_push, i_pop, i_flush, i_data,
//                       o_head (oldest entry), o_full, o_empty.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_skid_buffer
    import decode_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   i_push,
    input  wire logic   i_pop,
    input  wire logic   i_flush,
    input  fetch_t      i_data,
    output fetch_t      o_head,
    output logic        o_full,
    output logic        o_empty
);

    fetch_t      r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic        w_do_push;
    logic        w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Storage carries no reset; only the pointers/count define occupancy.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode stage. Fetch entries pass through a 2-entry skid
//               buffer (or bypass it when empty) into a registered decoded
//               output. Capacity is 3 instructions, order preserved.
//               Optional feature macro: DECODE_ILLEGAL_TRAP_EN.
//               Ports : clk, rst_n (sync, active-low), bus (decode_if.slave).
//               Parameters : XLEN (32 only), PC_INITIAL (out_pc when idle).
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter logic [31:0] PC_INITIAL = 32'h8000_0000
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    decode_if.slave     bus
);

    logic [XLEN-1:0] w_in_pc;
    fetch_t          w_in_data;
    fetch_t          w_fifo_head;
    fetch_t          w_src;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_accept;
    logic            w_load_out;
    logic            w_pop;
    logic            w_push;
    decoded_t        w_dec_next;
    decoded_t        w_idle;

    decoded_t        r_out;
    logic            r_out_valid;

    assign w_in_pc   = bus.in_pc;
    assign w_in_data = '{pc: w_in_pc, instr: bus.in_instr};

    // Held low through reset so fetch never pushes into a resetting pipe.
    assign bus.in_ready = rst_n && !w_fifo_full;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Output register is free when empty or being consumed this cycle.
    assign w_load_out = !r_out_valid || bus.out_ready;
    assign w_pop      = w_load_out && !w_fifo_empty;
    // Input bypasses the FIFO only when the FIFO is empty and the output
    // register is free; otherwise it queues behind older entries.
    assign w_push     = w_accept && !(w_load_out && w_fifo_empty);

    assign w_src      = w_fifo_empty ? w_in_data : w_fifo_head;
    assign w_dec_next = decode_instr(w_src.pc, w_src.instr);

    always_comb begin
        w_idle    = '0;
        w_idle.pc = PC_INITIAL;
    end

    decode_skid_buffer u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_data  (w_in_data),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_out_valid <= 1'b0;
            r_out       <= w_idle;
        end else if (w_load_out) begin
            if (!w_fifo_empty || w_accept) begin
                r_out_valid <= 1'b1;
                r_out       <= w_dec_next;
            end else begin
                r_out_valid <= 1'b0;
                r_out       <= w_idle;
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_out.pc;
    assign bus.out_opcode  = r_out.opcode;
    assign bus.out_rd      = r_out.rd;
    assign bus.out_rs1     = r_out.rs1;
    assign bus.out_rs2     = r_out.rs2;
    assign bus.out_funct3  = r_out.funct3;
    assign bus.out_funct7  = r_out.funct7;
    assign bus.out_imm     = r_out.imm;
    assign bus.out_rd_we   = r_out.rd_we;
    assign bus.out_illegal = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard testbench for decode_stage. Stimulus drives at the
//               falling edge; a monitor samples 1 time unit before each rising
//               edge, queues reference-model results for accepted inputs and
//               pops/compares on every output transfer.
//               Honors DECODE_ILLEGAL_TRAP_EN for the expected illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import decode_pkg::*;

    localparam logic [31:0] c_pc_init = 32'h8000_0000;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic c_trap = 1'b1;
`else
    localparam logic c_trap = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_if u_if ();

    decode_stage #(.XLEN(32), .PC_INITIAL(c_pc_init)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode built from the ISA field rules with integer arithmetic.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        int   s;
        int   v;
        logic known;
        logic writer;
        e.pc  = pc;
        e.opc = ins[6:0];
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.f3  = ins[14:12];
        e.f7  = ins[31:25];
        s      = ins[31] ? -1 : 0;
        known  = 1'b1;
        writer = 1'b0;
        v      = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: v = $signed(ins) >>> 20;
            7'h23: v = s * 4096 + int'(ins[31:25]) * 32 + int'(ins[11:7]);
            7'h63: v = s * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            7'h37, 7'h17: v = ins & 32'hFFFF_F000;
            7'h6F: v = s * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            7'h33, 7'h0F: v = 0;
            default: known = 1'b0;
        endcase
        case (ins[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: writer = 1'b1;
            default: writer = 1'b0;
        endcase
        e.imm = v;
        e.we  = writer && (ins[11:7] != 5'd0);
        e.ill = c_trap && !known;
        return e;
    endfunction

    function automatic exp_t act_bundle();
        exp_t a;
        a.pc  = u_if.out_pc;
        a.opc = u_if.out_opcode;
        a.rd  = u_if.out_rd;
        a.rs1 = u_if.out_rs1;
        a.rs2 = u_if.out_rs2;
        a.f3  = u_if.out_funct3;
        a.f7  = u_if.out_funct7;
        a.imm = u_if.out_imm;
        a.we  = u_if.out_rd_we;
        a.ill = u_if.out_illegal;
        return a;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [11];
        logic [31:0] r;
        int          pick;
        ops  = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        r    = $urandom;
        pick = $urandom_range(0, 11);
        if (pick == 11) return r;
        return {r[31:7], ops[pick]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        @(negedge clk);
        u_if.in_valid  = v;
        u_if.in_pc     = pc;
        u_if.in_instr  = ins;
        u_if.out_ready = ordy;
        u_if.flush     = fl;
    endtask

    // Monitor / scoreboard.
    initial begin : monitor
        exp_t e;
        exp_t cur;
        exp_t prev_b;
        logic prev_hold;
        prev_hold = 1'b0;
        prev_b    = '0;
        forever begin
            @(negedge clk);
            #4;
            cur = act_bundle();
            if (!rst_n) begin
                q.delete();
            end else begin
                if (prev_hold) check("hold_stable", 128'(cur), 128'(prev_b));
                if (u_if.out_valid && u_if.out_ready) begin
                    if (q.size() == 0) begin
                        check("spurious_output", 128'(cur.pc), 128'(0));
                    end else begin
                        e = q.pop_front();
                        check("bundle", 128'(cur), 128'(e));
                    end
                end
                if (u_if.flush) q.delete();
                else if (u_if.in_valid && u_if.in_ready) q.push_back(model(u_if.in_pc, u_if.in_instr));
            end
            prev_hold = rst_n && u_if.out_valid && !u_if.out_ready && !u_if.flush;
            prev_b    = cur;
        end
    end

    initial begin : stimulus
        logic [31:0] pcs [4];
        logic [31:0] ins [4];
        int          idx;
        int          acc;

        rst_n          = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_pc     = '0;
        u_if.in_instr  = '0;
        u_if.out_ready = 1'b1;
        u_if.flush     = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check("rst_in_ready",  128'(u_if.in_ready), 128'(0));
        check("rst_out_valid", 128'(u_if.out_valid), 128'(0));
        check("rst_out_pc",    128'(u_if.out_pc), 128'(c_pc_init));
        check("rst_out_imm",   128'(u_if.out_imm), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check("in_ready_after_release", 128'(u_if.in_ready), 128'(1));

        // addi x1, x0, 5
        drive(1'b1, 32'h8000_0000, 32'h0050_0093, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #4;
        check("addi_valid", 128'(u_if.out_valid), 128'(1));
        check("addi_rd",    128'(u_if.out_rd), 128'(1));
        check("addi_rs1",   128'(u_if.out_rs1), 128'(0));
        check("addi_imm",   128'(u_if.out_imm), 128'(5));
        check("addi_we",    128'(u_if.out_rd_we), 128'(1));

        // beq x0, x0, -4
        drive(1'b1, 32'h8000_0004, 32'hFE00_0EE3, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #4;
        check("beq_imm", 128'(u_if.out_imm), 128'(32'hFFFF_FFFC));
        check("beq_we",  128'(u_if.out_rd_we), 128'(0));

        // lui x5, 0x12345
        drive(1'b1, 32'h8000_0008, 32'h1234_52B7, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #4;
        check("lui_imm", 128'(u_if.out_imm), 128'(32'h1234_5000));
        check("lui_rd",  128'(u_if.out_rd), 128'(5));

        // all-zero word: unknown opcode
        drive(1'b1, 32'h8000_000C, 32'h0000_0000, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #4;
        check("zero_illegal", 128'(u_if.out_illegal), 128'(c_trap));
        check("zero_we",      128'(u_if.out_rd_we), 128'(0));

        // Capacity: out_ready low, offer 4 -> exactly 3 accepted.
        for (int k = 0; k < 4; k++) begin
            pcs[k] = 32'h8000_1000 + 32'(k * 4);
            ins[k] = gen_instr();
        end
        idx = 0;
        acc = 0;
        repeat (4) begin
            drive(1'b1, pcs[idx], ins[idx], 1'b0, 1'b0);
            #4;
            if (u_if.in_ready) begin
                acc++;
                idx++;
            end
        end
        check("cap_accepted", 128'(acc), 128'(3));
        check("cap_in_ready_low", 128'(u_if.in_ready), 128'(0));
        repeat (10) begin
            drive(idx < 4, pcs[idx % 4], ins[idx % 4], 1'b1, 1'b0);
            #4;
            if (idx < 4 && u_if.in_ready) idx++;
        end
        #1;
        check("cap_4th_accepted", 128'(idx), 128'(4));
        check("cap_drained", 128'(q.size()), 128'(0));

        // Flush with 3 held and a 4th offered.
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h8000_2000 + 32'(k * 4), gen_instr(), 1'b0, 1'b0);
        drive(1'b1, 32'h8000_200C, gen_instr(), 1'b0, 1'b1);
        #4;
        check("flush_full_before", 128'(u_if.in_ready), 128'(0));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #4;
        check("flush_out_valid", 128'(u_if.out_valid), 128'(0));
        check("flush_in_ready",  128'(u_if.in_ready), 128'(1));
        check("flush_out_pc",    128'(u_if.out_pc), 128'(c_pc_init));
        repeat (5) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            #4;
            check("flush_no_output", 128'(u_if.out_valid), 128'(0));
        end

        // Randomized traffic with occasional flushes.
        repeat (400) begin
            drive(($urandom % 10) < 7, $urandom & 32'hFFFF_FFFC, gen_instr(),
                  ($urandom % 10) < 7, ($urandom % 40) == 0);
        end
        repeat (6) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #5;
        check("random_drained", 128'(q.size()), 128'(0));

        // Reset while full.
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h8000_3000 + 32'(k * 4), gen_instr(), 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #4;
        check("rst_full_out_valid", 128'(u_if.out_valid), 128'(0));
        check("rst_full_out_pc",    128'(u_if.out_pc), 128'(c_pc_init));
        check("rst_full_in_ready",  128'(u_if.in_ready), 128'(0));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (4) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            #4;
            check("post_reset_idle", 128'(u_if.out_valid), 128'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
